// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Round-robin, burst-holding arbiter that shares the write port
//               of an asynchronous FIFO among NUM_REQ producers.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          write_clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          write_en,
    output logic [DATA_WIDTH-1:0]         write_data_out,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int SCAN_W = PTR_W + 1;
    localparam int CNT_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(MAX_BURST - 1);
    localparam logic [PTR_W-1:0] c_last_req  = PTR_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PTR_W-1:0]      r_rr_ptr;
    logic [PTR_W-1:0]      w_rr_ptr_nxt;
    logic [PTR_W-1:0]      r_owner;
    logic [PTR_W-1:0]      w_owner_nxt;
    logic [PTR_W-1:0]      w_owner_inc;
    logic [PTR_W-1:0]      w_pick;
    logic [SCAN_W-1:0]     w_scan;
    logic                  w_pick_found;
    logic [CNT_W-1:0]      r_beat_cnt;
    logic [CNT_W-1:0]      w_beat_cnt_nxt;
    logic [NUM_REQ-1:0]    r_grant;
    logic [NUM_REQ-1:0]    w_grant_nxt;
    logic                  w_active;
    logic                  w_owner_valid;
    logic [DATA_WIDTH-1:0] w_owner_data;
    logic                  w_burst_end;

    // First valid requester, scanning upward from the rotation pointer
    always_comb begin
        w_pick       = r_rr_ptr;
        w_pick_found = 1'b0;
        w_scan       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan = {1'b0, r_rr_ptr} + SCAN_W'(i);
            if (w_scan >= SCAN_W'(NUM_REQ)) begin
                w_scan = w_scan - SCAN_W'(NUM_REQ);
            end
            if (!w_pick_found && req_valid[w_scan[PTR_W-1:0]]) begin
                w_pick       = w_scan[PTR_W-1:0];
                w_pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_owner_valid = 1'b0;
        w_owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == PTR_W'(i)) begin
                w_owner_valid = req_valid[i];
                w_owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_owner_inc = (r_owner == c_last_req) ? '0 : r_owner + PTR_W'(1);

    // Reset gates the handshake combinationally so nothing is written in reset
    assign w_active       = reset_n && (r_state == BURST);
    assign req_ready      = (w_active && !full) ? r_grant : '0;
    assign write_en       = w_active && w_owner_valid && !full;
    assign write_data_out = (r_state == BURST) ? w_owner_data : '0;
    assign grant          = r_grant;
    assign busy           = (r_state == BURST);

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_owner_nxt    = r_owner;
        w_beat_cnt_nxt = r_beat_cnt;
        w_grant_nxt    = r_grant;
        w_burst_end    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt    = BURST;
                    w_owner_nxt    = w_pick;
                    w_grant_nxt    = NUM_REQ'(1) << w_pick;
                    w_beat_cnt_nxt = '0;
                end
            end
            BURST: begin
                if (!w_owner_valid) begin
                    w_burst_end = 1'b1;
                end else if (!full) begin
                    if (r_beat_cnt == c_last_beat) begin
                        w_burst_end = 1'b1;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_burst_end) begin
            w_state_nxt    = IDLE;
            w_rr_ptr_nxt   = w_owner_inc;
            w_grant_nxt    = '0;
            w_beat_cnt_nxt = '0;
        end
    end

    always_ff @(posedge write_clk) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_beat_cnt <= '0;
            r_grant    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            r_grant    <= w_grant_nxt;
        end
    end

    a_grant_onehot0: assert property (@(posedge write_clk) $onehot0(grant));
    a_no_write_full: assert property (@(posedge write_clk) write_en |-> !full);
    a_ready_onehot0: assert property (@(posedge write_clk) $onehot0(req_ready));
    a_we_handshake:  assert property (@(posedge write_clk) write_en == |(req_valid & req_ready));

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Scoreboard bench for fifo_write_arbiter (4 requesters, burst 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic            write_clk = 1'b0;
    logic            reset_n;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            full;
    logic            write_en;
    logic [DW-1:0]   write_data_out;
    logic [NR-1:0]   grant;
    logic            busy;

    fifo_write_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .write_clk      (write_clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .full           (full),
        .write_en       (write_en),
        .write_data_out (write_data_out),
        .grant          (grant),
        .busy           (busy)
    );

    always #5 write_clk = ~write_clk;

    logic [DW-1:0] src_mem [NR][32];
    int            src_len [NR];
    int            src_ptr [NR];
    logic [NR-1:0] src_en;
    logic [DW-1:0] sb_q [$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            wr_count = 0;

    // Producers present the head of their stream while enabled and not drained
    task automatic apply_inputs();
        for (int i = 0; i < NR; i++) begin
            if (src_en[i] && src_ptr[i] < src_len[i]) begin
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = src_mem[i][src_ptr[i]];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
            end
        end
    endtask

    task automatic load_src(input int idx, input logic [DW-1:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            src_mem[idx][k] = base + DW'(k);
        end
        src_len[idx] = n;
        src_ptr[idx] = 0;
    endtask

    // One clock: monitor writes against the scoreboard, then advance producers
    task automatic cycle();
        logic [NR-1:0] hs;
        logic [DW-1:0] exp;
        @(negedge write_clk);
        hs = req_valid & req_ready;
        if (write_en) begin
            wr_count++;
            n_tests++;
            if (full) begin
                n_fail++;
                $display("FAIL write_while_full: write_en=1 full=1 (required no write)");
            end
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: data=%h, scoreboard empty", write_data_out);
            end else begin
                exp = sb_q.pop_front();
                if (write_data_out !== exp) begin
                    n_fail++;
                    $display("FAIL write_data: got %h expected %h", write_data_out, exp);
                end
            end
        end
        @(posedge write_clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (hs[i]) src_ptr[i]++;
        end
        apply_inputs();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        full    = 1'b0;
        src_en  = '0;
        for (int i = 0; i < NR; i++) begin
            src_len[i] = 0;
            src_ptr[i] = 0;
        end
        sb_q.delete();
        apply_inputs();
        repeat (2) cycle();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic check_grant(input string name, input logic [NR-1:0] exp);
        n_tests++;
        if (grant !== exp) begin
            n_fail++;
            $display("FAIL %s: grant=%b expected %b", name, grant, exp);
        end
    endtask

    task automatic check_sb_empty(input string name);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d beats never written", name, sb_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        full    = 1'b0;
        for (int i = 0; i < NR; i++) load_src(i, DW'(8'hE0 + 8'(i)), 4);
        src_en = '1;
        apply_inputs();
        #1;
        n_tests++;
        if (write_en !== 1'b0 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_gating: write_en=%b req_ready=%b expected 0/0000", write_en, req_ready);
        end
        repeat (2) cycle();
        check_grant("reset_grant", 4'b0000);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: busy=%b expected 0", busy);
        end
        do_reset();
    endtask

    task automatic test_single();
        int w0;
        do_reset();
        load_src(2, 8'h10, 6);
        for (int k = 0; k < 6; k++) sb_q.push_back(DW'(8'h10 + 8'(k)));
        src_en = 4'b0100;
        apply_inputs();
        #1;
        check_grant("single_pre_grant", 4'b0000);
        cycle();
        check_grant("single_grant", 4'b0100);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy: busy=%b expected 1", busy);
        end
        w0 = wr_count;
        repeat (4) cycle();
        n_tests++;
        if (wr_count - w0 != 4) begin
            n_fail++;
            $display("FAIL single_burst_len: %0d writes expected 4", wr_count - w0);
        end
        check_grant("single_burst_end", 4'b0000);
        cycle();
        check_grant("single_regrant", 4'b0100);
        repeat (3) cycle();
        check_grant("single_drop_end", 4'b0000);
        check_sb_empty("single_sb");
    endtask

    task automatic test_fairness();
        int w0;
        do_reset();
        for (int i = 0; i < NR; i++) load_src(i, DW'(8'(i) << 4), 8);
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < MB; k++) begin
                sb_q.push_back(DW'((8'(r % NR) << 4) + 8'((r / NR) * MB + k)));
            end
        end
        src_en = '1;
        apply_inputs();
        #1;
        w0 = wr_count;
        for (int r = 0; r < 5; r++) begin
            cycle();
            check_grant($sformatf("fair_grant_%0d", r), NR'(1) << (r % NR));
            repeat (MB) cycle();
        end
        n_tests++;
        if (wr_count - w0 != 20) begin
            n_fail++;
            $display("FAIL fair_throughput: %0d writes in 25 cycles expected 20", wr_count - w0);
        end
        check_sb_empty("fair_sb");
    endtask

    task automatic test_full_stall();
        do_reset();
        load_src(1, 8'h30, 4);
        load_src(2, 8'h50, 1);
        for (int k = 0; k < 4; k++) sb_q.push_back(DW'(8'h30 + 8'(k)));
        sb_q.push_back(8'h50);
        src_en = 4'b0110;
        apply_inputs();
        #1;
        cycle();
        check_grant("stall_grant", 4'b0010);
        repeat (2) cycle();
        full = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin
            n_tests++;
            if (write_en !== 1'b0 || req_ready !== '0) begin
                n_fail++;
                $display("FAIL stall_%0d: write_en=%b req_ready=%b expected 0/0000", s, write_en, req_ready);
            end
            check_grant($sformatf("stall_hold_%0d", s), 4'b0010);
            cycle();
        end
        full = 1'b0;
        #1;
        repeat (2) cycle();
        check_grant("stall_end", 4'b0000);
        cycle();
        check_grant("stall_rotate", 4'b0100);
        repeat (2) cycle();
        check_sb_empty("stall_sb");
    endtask

    task automatic test_owner_drop();
        do_reset();
        load_src(0, 8'h60, 1);
        load_src(3, 8'h70, 2);
        sb_q.push_back(8'h60);
        sb_q.push_back(8'h70);
        sb_q.push_back(8'h71);
        src_en = 4'b1001;
        apply_inputs();
        #1;
        cycle();
        check_grant("drop_grant0", 4'b0001);
        repeat (2) cycle();
        check_grant("drop_idle", 4'b0000);
        cycle();
        check_grant("drop_grant3", 4'b1000);
        repeat (2) cycle();
        check_sb_empty("drop_sb");
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        load_src(2, 8'h80, 8);
        load_src(0, 8'h90, 2);
        sb_q.push_back(8'h80);
        sb_q.push_back(8'h81);
        src_en = 4'b0100;
        apply_inputs();
        #1;
        cycle();
        check_grant("rmid_grant2", 4'b0100);
        cycle();
        src_en = 4'b0101;
        apply_inputs();
        #1;
        cycle();
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (write_en !== 1'b0 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL rmid_gating: write_en=%b req_ready=%b expected 0/0000", write_en, req_ready);
        end
        cycle();
        check_grant("rmid_after_reset", 4'b0000);
        reset_n = 1'b1;
        sb_q.push_back(8'h90);
        sb_q.push_back(8'h91);
        #1;
        cycle();
        check_grant("rmid_restart", 4'b0001);
        repeat (2) cycle();
        check_sb_empty("rmid_sb");
    endtask

    task automatic test_backpressure();
        int w0;
        int budget;
        do_reset();
        for (int i = 0; i < NR; i++) load_src(i, DW'(8'hA0 + (8'(i) << 2) * 8'd1 + 8'(i * 12)), 8);
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < MB; k++) begin
                sb_q.push_back(src_mem[r % NR][(r / NR) * MB + k]);
            end
        end
        src_en = '1;
        apply_inputs();
        #1;
        w0 = wr_count;
        budget = 0;
        while (wr_count - w0 < 20 && budget < 300) begin
            cycle();
            full = ($urandom_range(0, 2) == 0);
            #1;
            budget++;
        end
        full = 1'b0;
        n_tests++;
        if (wr_count - w0 != 20) begin
            n_fail++;
            $display("FAIL bp_count: %0d writes within budget expected 20", wr_count - w0);
        end
        check_sb_empty("bp_sb");
    endtask

    initial begin
        reset_n   = 1'b0;
        full      = 1'b0;
        src_en    = '0;
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            src_len[i] = 0;
            src_ptr[i] = 0;
        end
        test_reset();
        test_single();
        test_fairness();
        test_full_stall();
        test_owner_drop();
        test_reset_mid_burst();
        test_backpressure();
        do_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
